bvudiv_skolem_checker: RTL and testbench

//  Sequential checker directly downstream of the 4-bit bvudiv Skolem function. Takes a
//  (s, t, x) triple, where x is the Skolem candidate for "x udiv s == t", recomputes
//  x udiv s with a serial restoring divider and classifies the result as PASS, FAIL or

---
 rtl/bvudiv_chk_pkg.sv | 26 ++
 rtl/bvudiv_skolem_checker_if.sv | 28 ++
 rtl/bvudiv_serial_core.sv | 84 ++++++++
 rtl/bvudiv_skolem_checker.sv | 173 +++++++++++++++++
 tb/tb_bvudiv_skolem_checker.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bvudiv_chk_pkg.sv
// Shared types and helpers for the bvudiv Skolem checker.
//   verdict_e : PASS / FAIL / VACUOUS classification of one (s, t, x) triple
//   state_e   : top-level FSM states
//   step_w    : width of a counter that must hold 0..w
package bvudiv_chk_pkg;

    localparam int unsigned DEF_W     = 4;
    localparam int unsigned DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        PASS    = 2'd0,
        FAIL    = 2'd1,
        VACUOUS = 2'd2
    } verdict_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned step_w(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bvudiv_skolem_checker_if.sv
// Triple-in / verdict-out handshake bundle of the bvudiv Skolem checker.
//   in_valid/in_ready/s/t/x       : triple channel (master drives valid and payload)
//   out_valid/out_ready/verdict/q : verdict channel (slave drives valid and payload)
interface bvudiv_skolem_checker_if #(
    parameter int unsigned W = 4
) ();

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] s;
    logic [W-1:0] t;
    logic [W-1:0] x;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   verdict;
    logic [W-1:0] q_out;

    modport master (
        output in_valid, s, t, x, out_ready,
        input  in_ready, out_valid, verdict, q_out
    );

    modport slave (
        input  in_valid, s, t, x, out_ready,
        output in_ready, out_valid, verdict, q_out
    );

endinterface

// File: rtl/bvudiv_serial_core.sv
// Serial restoring unsigned divider, one quotient bit per cycle, MSB first.
// A zero divisor yields an all-ones quotient but still takes W cycles so the
// latency never depends on the operands.
//   clk, rst_n : clock, async active-low reset
//   start      : load dividend/divisor (ignored while busy)
//   dividend   : x
//   divisor    : s
//   busy       : W-step computation in progress
//   done       : one-cycle pulse, quotient valid
//   quotient   : x udiv s
module bvudiv_serial_core
    import bvudiv_chk_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int unsigned STEP_W = step_w(W);

    logic [W-1:0]      dvd_q;
    logic [W-1:0]      dsr_q;
    logic [W-1:0]      rem_q;
    logic [STEP_W-1:0] step_q;

    logic [W:0]   trial_c;
    logic         qbit_c;
    logic [W-1:0] rem_next_c;

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract when it covers the divisor.
    always_comb begin
        trial_c    = {rem_q, dvd_q[W-1]};
        qbit_c     = 1'b0;
        rem_next_c = trial_c[W-1:0];
        if (dsr_q == '0) begin
            qbit_c     = 1'b1;
            rem_next_c = rem_q;
        end else if (trial_c >= {1'b0, dsr_q}) begin
            qbit_c     = 1'b1;
            rem_next_c = W'(trial_c - {1'b0, dsr_q});
        end
    end

    // Operand load, step sequencing and quotient shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            step_q   <= '0;
            quotient <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (start && !busy) begin
            dvd_q    <= dividend;
            dsr_q    <= divisor;
            rem_q    <= '0;
            step_q   <= '0;
            quotient <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else if (busy) begin
            dvd_q    <= dvd_q << 1;
            rem_q    <= rem_next_c;
            quotient <= W'({quotient, qbit_c});
            step_q   <= step_q + STEP_W'(1);
            if (step_q == STEP_W'(W - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/bvudiv_skolem_checker.sv
// Checks a bvudiv Skolem candidate: recomputes x udiv s serially and classifies
// the triple as PASS, FAIL or VACUOUS, with saturating tallies of each verdict.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear of the three tallies (wins over a same-cycle handshake)
//   bus        : triple-in / verdict-out handshake bundle (slave side)
//   pass_cnt   : saturating PASS tally
//   fail_cnt   : saturating FAIL tally
//   vac_cnt    : saturating VACUOUS tally
module bvudiv_skolem_checker
    import bvudiv_chk_pkg::*;
#(
    parameter int unsigned W     = DEF_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    bvudiv_skolem_checker_if.slave bus,
    output logic [CNT_W-1:0]      pass_cnt,
    output logic [CNT_W-1:0]      fail_cnt,
    output logic [CNT_W-1:0]      vac_cnt
);

    localparam int unsigned PW       = 2 * W;
    localparam logic [W-1:0] ONES    = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e       state_q, state_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    verdict_e     verdict_q, verdict_d;
    logic [W-1:0] q_out_q, q_out_d;

    logic [W-1:0] t_q;
    logic         cond_q;

    logic [PW-1:0] prod_c;
    logic          cond_c;
    logic          accept_c;
    logic          fire_c;
    verdict_e      verdict_c;

    logic         core_busy;
    logic         core_done;
    logic [W-1:0] core_q;

    // Invertibility: some x satisfies x udiv s == t.
    always_comb begin
        prod_c = PW'(bus.s) * PW'(bus.t);
        if (bus.s == '0) begin
            cond_c = (bus.t == ONES);
        end else begin
            cond_c = (prod_c[PW-1:W] == '0);
        end
    end

    assign accept_c = in_ready_q && bus.in_valid && !core_busy;
    assign fire_c   = out_valid_q && bus.out_ready;

    always_comb begin
        if (!cond_q) begin
            verdict_c = VACUOUS;
        end else if (core_q == t_q) begin
            verdict_c = PASS;
        end else begin
            verdict_c = FAIL;
        end
    end

    bvudiv_serial_core #(
        .W (W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept_c),
        .dividend (bus.x),
        .divisor  (bus.s),
        .busy     (core_busy),
        .done     (core_done),
        .quotient (core_q)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        verdict_d   = verdict_q;
        q_out_d     = q_out_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d    = DIV;
                    in_ready_d = 1'b0;
                end
            end
            DIV: begin
                if (core_done) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    verdict_d   = verdict_c;
                    q_out_d     = core_q;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            verdict_q   <= PASS;
            q_out_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            verdict_q   <= verdict_d;
            q_out_q     <= q_out_d;
        end
    end

    // Target and invertibility flag captured with the triple.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q    <= '0;
            cond_q <= 1'b0;
        end else if (accept_c) begin
            t_q    <= bus.t;
            cond_q <= cond_c;
        end
    end

    // Saturating verdict tallies; clr takes priority over a same-cycle handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            vac_cnt  <= '0;
        end else if (clr) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            vac_cnt  <= '0;
        end else if (fire_c) begin
            case (verdict_q)
                PASS:    if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
                FAIL:    if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
                VACUOUS: if (vac_cnt  != CNT_MAX) vac_cnt  <= vac_cnt  + CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.verdict   = verdict_q;
    assign bus.q_out     = q_out_q;

endmodule

// File: tb/tb_bvudiv_skolem_checker.sv
// Scoreboard bench for the bvudiv Skolem checker: directed triples, backpressure,
// mid-division reset, clear priority, exhaustive sweep and tally saturation.
module tb_bvudiv_skolem_checker;

    typedef struct packed {
        logic [3:0] q;
        logic [1:0] v;
    } exp_t;

    logic clk;
    logic rst_n;
    logic clr;
    logic clr2;
    logic [15:0] pass_cnt, fail_cnt, vac_cnt;
    logic [1:0]  pass2, fail2, vac2;

    int n_chk;
    int n_err;
    int pass_m, fail_m, vac_m;
    exp_t sb[$];

    bvudiv_skolem_checker_if #(.W(4)) bus ();
    bvudiv_skolem_checker_if #(.W(4)) bus2 ();

    bvudiv_skolem_checker #(.W(4), .CNT_W(16)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .bus      (bus),
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt),
        .vac_cnt  (vac_cnt)
    );

    bvudiv_skolem_checker #(.W(4), .CNT_W(2)) u_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr2),
        .bus      (bus2),
        .pass_cnt (pass2),
        .fail_cnt (fail2),
        .vac_cnt  (vac2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference: q = x udiv s (all-ones for s==0); verdict from invertibility and match.
    function automatic void golden(input logic [3:0] s, input logic [3:0] t, input logic [3:0] x,
                                   output logic [3:0] q, output logic [1:0] v);
        bit cond;
        if (s == 4'd0) begin
            q    = 4'hF;
            cond = (t == 4'hF);
        end else begin
            q    = 4'(int'(x) / int'(s));
            cond = (int'(s) * int'(t)) < 16;
        end
        if (!cond)       v = 2'd2;
        else if (q == t) v = 2'd0;
        else             v = 2'd1;
    endfunction

    task automatic tally(input logic [1:0] v);
        case (v)
            2'd0: pass_m++;
            2'd1: fail_m++;
            default: vac_m++;
        endcase
    endtask

    task automatic check_counts(input string name);
        n_chk++;
        if (pass_cnt !== 16'(pass_m) || fail_cnt !== 16'(fail_m) || vac_cnt !== 16'(vac_m)) begin
            n_err++;
            $display("FAIL %s counters: got p=%0d f=%0d v=%0d, required p=%0d f=%0d v=%0d",
                     name, pass_cnt, fail_cnt, vac_cnt, pass_m, fail_m, vac_m);
        end
    endtask

    // Push one triple through, check latency, result and (optionally) tallies.
    task automatic do_triple(input logic [3:0] s, input logic [3:0] t, input logic [3:0] x,
                             input bit chk_lat, input bit chk_cnt);
        int cyc;
        exp_t e;
        logic [3:0] gq;
        logic [1:0] gv;
        golden(s, t, x, gq, gv);
        cyc = 0;
        while (!bus.in_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        if (!bus.in_ready) begin
            n_chk++; n_err++;
            $display("FAIL accept_wait: in_ready got 0, required 1");
            return;
        end
        bus.s = s; bus.t = t; bus.x = x; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        sb.push_back('{q: gq, v: gv});
        cyc = 0;
        while (!bus.out_valid && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        n_chk++;
        if (!bus.out_valid) begin
            n_err++;
            $display("FAIL out_valid_wait s=%0d t=%0d x=%0d: got 0, required 1", s, t, x);
            void'(sb.pop_front());
            return;
        end
        if (chk_lat) begin
            if (cyc != 5) begin
                n_err++;
                $display("FAIL latency s=%0d t=%0d x=%0d: got %0d edges, required 5", s, t, x, cyc);
            end
            n_chk++;
        end
        e = sb.pop_front();
        if ({bus.q_out, bus.verdict} !== {e.q, e.v}) begin
            n_err++;
            $display("FAIL result s=%0d t=%0d x=%0d: got q=%0d v=%0d, required q=%0d v=%0d",
                     s, t, x, bus.q_out, bus.verdict, e.q, e.v);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        tally(e.v);
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL out_valid_drop: got %b, required 0", bus.out_valid);
        end
        if (chk_cnt) check_counts("handshake");
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.verdict !== 2'd0 ||
            bus.q_out !== 4'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b v=%0d q=%0d, required 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.verdict, bus.q_out);
        end
        check_counts("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        do_triple(4'd3, 4'd2,  4'd6, 1'b1, 1'b1);
        do_triple(4'd3, 4'd2,  4'd7, 1'b1, 1'b1);
        do_triple(4'd3, 4'd2,  4'd5, 1'b1, 1'b1);
        do_triple(4'd0, 4'd15, 4'd9, 1'b1, 1'b1);
        do_triple(4'd0, 4'd3,  4'd0, 1'b1, 1'b1);
        do_triple(4'd5, 4'd4,  4'd0, 1'b1, 1'b1);
        do_triple(4'd1, 4'd15, 4'd15, 1'b1, 1'b1);
    endtask

    task automatic test_backpressure;
        int cyc;
        bus.s = 4'd7; bus.t = 4'd2; bus.x = 4'd15; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        for (int i = 0; i < 10; i++) begin
            bus.s = 4'd1; bus.t = 4'd1; bus.x = 4'd1; bus.in_valid = 1'b1;
            n_chk++;
            if (bus.out_valid !== 1'b1 || bus.verdict !== 2'd0 || bus.q_out !== 4'd2 ||
                bus.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL backpressure_hold cyc %0d: got vld=%b v=%0d q=%0d rdy=%b, required 1 0 2 0",
                         i, bus.out_valid, bus.verdict, bus.q_out, bus.in_ready);
            end
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        tally(2'd0);
        check_counts("backpressure");
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            n_chk++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL ignored_triple cyc %0d: got vld=%b rdy=%b, required 0 1",
                         i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_reset_mid_div;
        bus.s = 4'd2; bus.t = 4'd3; bus.x = 4'd6; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.verdict !== 2'd0 ||
            bus.q_out !== 4'd0 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || vac_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL mid_div_reset: got rdy=%b vld=%b v=%0d q=%0d p=%0d f=%0d c=%0d, required 1 0 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.verdict, bus.q_out, pass_cnt, fail_cnt, vac_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        pass_m = 0; fail_m = 0; vac_m = 0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL discarded_triple: got out_valid=%b, required 0", bus.out_valid);
        end
        do_triple(4'd4, 4'd3, 4'd13, 1'b1, 1'b1);
    endtask

    task automatic test_clr;
        int cyc;
        bus.s = 4'd2; bus.t = 4'd7; bus.x = 4'd15; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        pass_m = 0; fail_m = 0; vac_m = 0;
        check_counts("clr_in_flight");
        cyc = 0;
        while (!bus.out_valid && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.verdict !== 2'd0 || bus.q_out !== 4'd7) begin
            n_err++;
            $display("FAIL clr_undisturbed: got vld=%b v=%0d q=%0d, required 1 0 7",
                     bus.out_valid, bus.verdict, bus.q_out);
        end
        bus.out_ready = 1'b1;
        clr = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        clr = 1'b0;
        check_counts("clr_with_handshake");
    endtask

    task automatic test_exhaustive;
        for (int s = 0; s < 16; s++)
            for (int t = 0; t < 16; t++)
                for (int x = 0; x < 16; x++)
                    do_triple(4'(s), 4'(t), 4'(x), 1'b0, 1'b0);
        check_counts("exhaustive");
    endtask

    task automatic test_saturation;
        int cyc;
        for (int i = 0; i < 5; i++) begin
            bus2.s = 4'd3; bus2.t = 4'd2; bus2.x = 4'd6; bus2.in_valid = 1'b1;
            @(posedge clk); #1;
            bus2.in_valid = 1'b0;
            cyc = 0;
            while (!bus2.out_valid && cyc < 50) begin
                @(posedge clk); #1; cyc++;
            end
            bus2.out_ready = 1'b1;
            @(posedge clk); #1;
            bus2.out_ready = 1'b0;
            n_chk++;
            if (pass2 !== 2'((i + 1 > 3) ? 3 : i + 1)) begin
                n_err++;
                $display("FAIL saturation step %0d: got %0d, required %0d",
                         i, pass2, (i + 1 > 3) ? 3 : i + 1);
            end
        end
        clr2 = 1'b1;
        @(posedge clk); #1;
        clr2 = 1'b0;
        n_chk++;
        if (pass2 !== 2'd0) begin
            n_err++;
            $display("FAIL saturation_clr: got %0d, required 0", pass2);
        end
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        pass_m = 0; fail_m = 0; vac_m = 0;
        clr = 1'b0; clr2 = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.s = '0; bus.t = '0; bus.x = '0;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
        bus2.s = '0; bus2.t = '0; bus2.x = '0;

        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_div();
        test_clr();
        test_exhaustive();
        test_saturation();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
